pixel_packet_queue: RTL and testbench

Parametrised elastic queue between the packet generator and the I2C slave of the Tiny Canvas drawing pipeline. Today the I2C slave exposes only the most recent pixel, so a slow host silently loses brush-expanded and symmetry-expanded pixels. This block buffers up to DEPTH pixel packets (x, y, colour) and releases them one per host read. It adds a selectable overflow policy, a sticky overflow flag, a saturating drop counter, a fill-level interrupt and a flush used on undo/redo.

---
 rtl/canvas_pkg.sv | 22 ++
 rtl/pkt_fifo_mem.sv | 29 ++
 rtl/pixel_packet_queue.sv | 128 ++++++++++++
 tb/tb_pixel_packet_queue.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/canvas_pkg.sv
// canvas_pkg: types and constants shared across the Tiny Canvas pixel path.
//   COORD_W / COLOR_W : default coordinate and colour widths
//   DROP_CNT_W        : width of the saturating lost-packet counter
//   pixel_pkt_t       : one pixel packet {x, y, color}
//   sat_inc           : increment that sticks at all-ones
package canvas_pkg;

  localparam int unsigned COORD_W    = 8;
  localparam int unsigned COLOR_W    = 3;
  localparam int unsigned DROP_CNT_W = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] color;
  } pixel_pkt_t;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pkt_fifo_mem.sv
// pkt_fifo_mem: DEPTH x PKT_W register array, one synchronous write port and
// one asynchronous read port. Contents are not reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : combinational read data at raddr_i
module pkt_fifo_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PKT_W = 19
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [PKT_W-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [PKT_W-1:0]         rdata_o
);

  logic [PKT_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pixel_packet_queue.sv
// pixel_packet_queue: elastic queue of pixel packets between the packet
// generator and the I2C slave. Holds up to DEPTH packets, releases one per
// host pop, with drop-newest or evict-oldest overflow policy.
//   push_valid/push_x/push_y/push_color/push_ready : producer side
//   pop_req/pop_valid/pop_x/pop_y/pop_color         : host side (head shown comb.)
//   count, level_irq                                : occupancy and threshold flag
//   overflow, drop_cnt, clr_overflow                : sticky loss flag, lost-packet count
//   flush                                           : empties the queue
module pixel_packet_queue #(
  parameter int unsigned COORD_W   = canvas_pkg::COORD_W,
  parameter int unsigned COLOR_W   = canvas_pkg::COLOR_W,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned OVERWRITE = 0,
  parameter int unsigned THRESHOLD = DEPTH / 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push_valid,
  input  logic [COORD_W-1:0]               push_x,
  input  logic [COORD_W-1:0]               push_y,
  input  logic [COLOR_W-1:0]               push_color,
  output logic                             push_ready,
  input  logic                             pop_req,
  output logic                             pop_valid,
  output logic [COORD_W-1:0]               pop_x,
  output logic [COORD_W-1:0]               pop_y,
  output logic [COLOR_W-1:0]               pop_color,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic                             level_irq,
  output logic                             overflow,
  output logic [canvas_pkg::DROP_CNT_W-1:0] drop_cnt,
  input  logic                             clr_overflow,
  input  logic                             flush
);
  import canvas_pkg::*;

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned PKT_W = 2 * COORD_W + COLOR_W;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] THR_LVL  = CW'(THRESHOLD);

  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d, level_q, level_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  full, empty, push_do, pop_do, evict, drop;
  logic [PKT_W-1:0]      rdata;

  always_comb begin
    full       = (count_q == FULL_LVL);
    empty      = (count_q == '0);
    push_ready = (OVERWRITE != 0) ? 1'b1 : !full;
    pop_do     = pop_req && !empty && !flush;
    push_do    = push_valid && push_ready && !flush;
    // Evict-oldest only when full and the host is not popping this cycle;
    // a concurrent pop already frees the slot.
    evict      = (OVERWRITE != 0) && push_do && full && !pop_do;
    drop       = push_valid && full && !flush && ((OVERWRITE == 0) || !pop_do);

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_do)          wptr_d = wptr_q + AW'(1);
      if (pop_do || evict)  rptr_d = rptr_q + AW'(1);
      if (push_do && !pop_do && !evict) count_d = count_q + CW'(1);
      else if (pop_do && !push_do)      count_d = count_q - CW'(1);
    end

    // A drop in the same cycle as a clear restarts the count at one.
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (drop) begin
      ovf_d  = 1'b1;
      drop_d = clr_overflow ? DROP_CNT_W'(1) : sat_inc(drop_q);
    end else if (clr_overflow) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end

    level_d = (count_d >= THR_LVL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
      level_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      level_q <= level_d;
    end
  end

  pkt_fifo_mem #(
    .DEPTH (DEPTH),
    .PKT_W (PKT_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push_do),
    .waddr_i (wptr_q),
    .wdata_i ({push_x, push_y, push_color}),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );

  // Head is masked while empty so stale or uninitialised array contents
  // never appear on the host side.
  assign {pop_x, pop_y, pop_color} = empty ? '0 : rdata;
  assign pop_valid = !empty;
  assign count     = count_q;
  assign level_irq = level_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_pixel_packet_queue.sv
// Bench: two queues (drop-newest and evict-oldest) share one stimulus stream;
// a queue-based reference model per instance feeds a scoreboard that a
// separate monitor drains.
module tb_pixel_packet_queue;
  import canvas_pkg::*;

  localparam int DEPTH = 8;
  localparam int THR   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       push_valid = 1'b0;
  logic [7:0] push_x = '0, push_y = '0;
  logic [2:0] push_color = '0;
  logic       pop_req = 1'b0, flush = 1'b0, clr_overflow = 1'b0;

  logic       pr [2], pv [2], lvl [2], ovf [2];
  logic [7:0] px [2], py [2], dc [2];
  logic [2:0] pc [2];
  logic [3:0] cnt [2];

  pixel_packet_queue #(.COORD_W(8), .COLOR_W(3), .DEPTH(DEPTH), .OVERWRITE(0), .THRESHOLD(THR)) u_dut0 (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_x(push_x), .push_y(push_y),
    .push_color(push_color), .push_ready(pr[0]), .pop_req(pop_req), .pop_valid(pv[0]),
    .pop_x(px[0]), .pop_y(py[0]), .pop_color(pc[0]), .count(cnt[0]), .level_irq(lvl[0]),
    .overflow(ovf[0]), .drop_cnt(dc[0]), .clr_overflow(clr_overflow), .flush(flush));

  pixel_packet_queue #(.COORD_W(8), .COLOR_W(3), .DEPTH(DEPTH), .OVERWRITE(1), .THRESHOLD(THR)) u_dut1 (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_x(push_x), .push_y(push_y),
    .push_color(push_color), .push_ready(pr[1]), .pop_req(pop_req), .pop_valid(pv[1]),
    .pop_x(px[1]), .pop_y(py[1]), .pop_color(pc[1]), .count(cnt[1]), .level_irq(lvl[1]),
    .overflow(ovf[1]), .drop_cnt(dc[1]), .clr_overflow(clr_overflow), .flush(flush));

  typedef struct {
    int k; int cnt; int pr; int lvl; int ovf; int pv; int dc; pixel_pkt_t head;
  } stat_t;
  typedef struct { int k; pixel_pkt_t p; } dexp_t;

  stat_t      sq [$];
  dexp_t      dq [$];
  pixel_pkt_t mq0 [$], mq1 [$];
  int         movf [2];
  int         mdrop [2];
  int         vectors = 0;
  int         miscompares = 0;

  task automatic chk(input string name, input int k, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Reference: a packet queue plus the loss rules, expressed on whole packets.
  task automatic model_step(input int k, input bit pv_, input pixel_pkt_t p,
                            input bit pop_, input bit fl, input bit clr);
    pixel_pkt_t q [$];
    bit popping, full, drop;
    if (k == 0) q = mq0; else q = mq1;
    popping = pop_ && q.size() > 0;
    full    = q.size() == DEPTH;
    drop    = 1'b0;
    if (fl) q.delete();
    else if (pv_) begin
      if (!full) begin
        if (popping) void'(q.pop_front());
        q.push_back(p);
      end else if (k == 1) begin
        void'(q.pop_front());
        q.push_back(p);
        drop = !popping;
      end else begin
        if (popping) void'(q.pop_front());
        drop = 1'b1;
      end
    end else if (popping) void'(q.pop_front());
    if (drop) begin
      movf[k]  = 1;
      mdrop[k] = clr ? 1 : (mdrop[k] < 255 ? mdrop[k] + 1 : 255);
    end else if (clr) begin
      movf[k]  = 0;
      mdrop[k] = 0;
    end
    if (k == 0) mq0 = q; else mq1 = q;
  endtask

  task automatic do_cycle(input bit pv_, input logic [7:0] x, input logic [7:0] y,
                          input logic [2:0] c, input bit pop_, input bit fl, input bit clr);
    pixel_pkt_t p;
    pixel_pkt_t q [$];
    stat_t s;
    p.x = x; p.y = y; p.color = c;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (k == 0) q = mq0; else q = mq1;
      s.k   = k;
      s.cnt = q.size();
      s.pr  = (k == 1 || q.size() < DEPTH) ? 1 : 0;
      s.lvl = (q.size() >= THR) ? 1 : 0;
      s.ovf = movf[k];
      s.dc  = mdrop[k];
      s.pv  = (q.size() > 0) ? 1 : 0;
      s.head = (q.size() > 0) ? q[0] : '0;
      sq.push_back(s);
      if (pop_ && !fl && q.size() > 0) dq.push_back('{k: k, p: q[0]});
    end
    push_valid = pv_; push_x = x; push_y = y; push_color = c;
    pop_req = pop_; flush = fl; clr_overflow = clr;
    for (int k = 0; k < 2; k++) model_step(k, pv_, p, pop_, fl, clr);
  endtask

  task automatic idle();
    do_cycle(1'b0, 8'h0, 8'h0, 3'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input int i);
    do_cycle(1'b1, 8'(i), 8'(2 * i), 3'(i % 8), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    do_cycle(1'b0, 8'h0, 8'h0, 3'h0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: compares status every cycle and the consumed head on each pop.
  initial begin
    stat_t s;
    dexp_t d;
    forever begin
      @(negedge clk);
      #3;
      for (int k = 0; k < 2; k++) begin
        if (sq.size() == 0) break;
        s = sq.pop_front();
        chk("count", s.k, int'(cnt[s.k]), s.cnt);
        chk("push_ready", s.k, int'(pr[s.k]), s.pr);
        chk("level_irq", s.k, int'(lvl[s.k]), s.lvl);
        chk("overflow", s.k, int'(ovf[s.k]), s.ovf);
        chk("drop_cnt", s.k, int'(dc[s.k]), s.dc);
        chk("pop_valid", s.k, int'(pv[s.k]), s.pv);
        chk("head_x", s.k, int'(px[s.k]), int'(s.head.x));
        chk("head_y", s.k, int'(py[s.k]), int'(s.head.y));
        chk("head_color", s.k, int'(pc[s.k]), int'(s.head.color));
      end
      for (int k = 0; k < 2; k++) begin
        if (pop_req && !flush && !rst && pv[k]) begin
          if (dq.size() == 0 || dq[0].k != k) begin
            chk("pop_expected", k, 1, 0);
          end else begin
            d = dq.pop_front();
            chk("pop_data", k, int'({px[k], py[k], pc[k]}), int'(d.p));
          end
        end
      end
    end
  end

  task automatic async_reset_check();
    @(negedge clk);
    push_valid = 1'b0; pop_req = 1'b0; flush = 1'b0; clr_overflow = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_push_ready", k, int'(pr[k]), 1);
      chk("rst_pop_valid", k, int'(pv[k]), 0);
      chk("rst_pop_data", k, int'({px[k], py[k], pc[k]}), 0);
      chk("rst_count", k, int'(cnt[k]), 0);
      chk("rst_level_irq", k, int'(lvl[k]), 0);
      chk("rst_overflow", k, int'(ovf[k]), 0);
      chk("rst_drop_cnt", k, int'(dc[k]), 0);
      movf[k] = 0; mdrop[k] = 0;
    end
    mq0.delete(); mq1.delete(); sq.delete(); dq.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int ph;
    bit pv_, pp_;
    movf = '{0, 0}; mdrop = '{0, 0};
    @(negedge clk);
    rst = 1'b0;
    idle();

    for (int i = 0; i < 8; i++) push(i);                    // fill
    do_cycle(1'b1, 8'hAA, 8'h55, 3'h5, 1'b0, 1'b0, 1'b0);   // full push: drop vs evict
    for (int i = 0; i < 10; i++) pop();                      // drain, extra pops ignored
    do_cycle(1'b0, 8'h0, 8'h0, 3'h0, 1'b0, 1'b0, 1'b1);     // clear

    for (int i = 0; i < 3; i++) push(16 + i);                // push+pop at count 3
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 8'(40 + i), 8'(i), 3'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) pop();
    do_cycle(1'b1, 8'h77, 8'h66, 3'h3, 1'b1, 1'b0, 1'b0);   // push+pop while empty
    idle();
    pop();

    for (int i = 0; i < 8; i++) push(i);                     // flush with count 5, overflow 1
    push(99);
    for (int i = 0; i < 3; i++) pop();
    do_cycle(1'b1, 8'h12, 8'h34, 3'h1, 1'b0, 1'b1, 1'b0);
    idle();
    for (int i = 0; i < 8; i++) push(i + 100);               // clear coincident with drop
    do_cycle(1'b1, 8'hBB, 8'hCC, 3'h2, 1'b0, 1'b0, 1'b1);
    idle();

    for (int i = 0; i < 300; i++) push(i);                   // drop counter saturation
    idle();
    do_cycle(1'b0, 8'h0, 8'h0, 3'h0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 1500; i++) begin                     // randomized traffic
      ph  = (i / 100) % 3;
      pv_ = (ph == 0) ? ($urandom_range(0, 9) < 8) : (ph == 1) ? ($urandom_range(0, 9) < 2) : $urandom_range(0, 1);
      pp_ = (ph == 1) ? ($urandom_range(0, 9) < 8) : (ph == 0) ? ($urandom_range(0, 9) < 2) : $urandom_range(0, 1);
      do_cycle(pv_, 8'($urandom), 8'($urandom), 3'($urandom), pp_,
               $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0);
    end

    do_cycle(1'b0, 8'h0, 8'h0, 3'h0, 1'b0, 1'b1, 1'b0);     // reset mid-stream at count 6
    for (int i = 0; i < 6; i++) push(200 + i);
    idle();
    async_reset_check();
    push(7);
    idle();
    idle();

    @(negedge clk);
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
